// File: rtl/multicycle_controller_if.sv
// Instruction/data memory handshake bundle for the multicycle controller.
// Signals:
//   instr      - instruction word from instruction memory
//   imem_req   - controller requests an instruction fetch
//   imem_ready - instruction word valid this cycle
//   dmem_req   - controller requests a data access
//   dmem_we    - data access is a store
//   dmem_ready - data access completes this cycle
// master: controller side; slave: memory side.
interface multicycle_controller_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] instr;
  logic            imem_req;
  logic            imem_ready;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ready;

  modport master (
    input  instr, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we
  );

  modport slave (
    output instr, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for a small RV32 subset (LW, SW, ADDI, LUI, R-type
// ADD/SUB/AND/OR/XOR/SLT, ECALL). Fetches into an internal IR, decodes from IR
// only, and sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-high reset
//   bus (master)      - imem/dmem request/ready handshakes and instruction word
//   rs1, rs2, rd      - register indices taken from IR
//   irWrite, pcWrite  - IR load / PC advance strobes (fetch handshake)
//   regWrite          - register-file write strobe (WB, never for x0)
//   aluSrcImm         - ALU operand B is the immediate
//   ALUControl        - ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 PASSB=6
//   halt, illegal     - sticky ECALL / trap indications
//   state             - current FSM state code
module multicycle_controller #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_controller_if.master bus,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  irWrite,
  output logic                  pcWrite,
  output logic                  regWrite,
  output logic                  aluSrcImm,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  halt,
  output logic                  illegal,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(6);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_e          state_q, state_d;
  logic [XLEN-1:0] ir;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_load, is_store, is_addi, is_op, is_lui, is_ecall;
  logic       op_ok, legal;
  logic [ALU_CTRL_W-1:0] op_alu;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];
  assign rs1    = REG_ADDR_W'(ir[19:15]);
  assign rs2    = REG_ADDR_W'(ir[24:20]);
  assign rd     = REG_ADDR_W'(ir[11:7]);
  assign state  = state_q;

  assign is_load  = (opcode == OPC_LOAD)  && (f3 == 3'b010);
  assign is_store = (opcode == OPC_STORE) && (f3 == 3'b010);
  assign is_addi  = (opcode == OPC_OPIMM) && (f3 == 3'b000);
  assign is_op    = (opcode == OPC_OP);
  assign is_lui   = (opcode == OPC_LUI);
  assign is_ecall = (opcode == OPC_SYSTEM) && (ir[31:7] == 25'd0);
  assign legal    = is_load || is_store || is_addi || is_lui || (is_op && op_ok);

  // R-type function decode; any unlisted f7/f3 pair is illegal
  always_comb begin
    op_ok  = 1'b1;
    op_alu = ALU_ADD;
    case ({f7, f3})
      10'b0000000_000: op_alu = ALU_ADD;
      10'b0100000_000: op_alu = ALU_SUB;
      10'b0000000_111: op_alu = ALU_AND;
      10'b0000000_110: op_alu = ALU_OR;
      10'b0000000_100: op_alu = ALU_XOR;
      10'b0000000_010: op_alu = ALU_SLT;
      default:         op_ok  = 1'b0;
    endcase
  end

  // State and instruction register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && bus.imem_ready) begin
        ir <= XLEN'(bus.instr);
      end
    end
  end

  // Next state and Moore outputs; only the fetch strobes see imem_ready
  always_comb begin
    state_d      = state_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    regWrite     = 1'b0;
    aluSrcImm    = 1'b0;
    ALUControl   = ALU_ADD;
    halt         = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        // reset also masks the strobes while state is held at FETCH
        if (bus.imem_ready && !reset) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal)         state_d = S_EXEC;
        else if (is_ecall) state_d = S_HALT;
        else               state_d = S_TRAP;
      end
      S_EXEC: begin
        aluSrcImm  = !is_op;
        ALUControl = is_op ? op_alu : (is_lui ? ALU_PASSB : ALU_ADD);
        state_d    = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = is_store;
        aluSrcImm    = 1'b1;
        if (bus.dmem_ready) state_d = is_store ? S_FETCH : S_WB;
      end
      S_WB: begin
        regWrite = (ir[11:7] != 5'd0);
        state_d  = S_FETCH;
      end
      S_HALT:  halt    = 1'b1;
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: expected state sequences and
// memory/writeback events are queued when an instruction is driven and
// consumed as the DUT produces them.
module tb_multicycle_controller;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_ECALL = 3;
  localparam int K_TRAP  = 4;

  logic       clk;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       irWrite, pcWrite, regWrite, aluSrcImm;
  logic [2:0] ALUControl;
  logic       halt, illegal;
  logic [2:0] state;

  int checks;
  int errors;

  logic [7:0]  exp_events [$];
  logic [2:0]  exp_states [$];
  logic [31:0] op_words [4];
  logic [2:0]  op_alus  [4];

  multicycle_controller_if #(.XLEN(32)) bus ();

  multicycle_controller #(
    .XLEN(32), .REG_ADDR_W(5), .ALU_CTRL_W(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite),
    .aluSrcImm(aluSrcImm), .ALUControl(ALUControl),
    .halt(halt), .illegal(illegal), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [7:0] obs);
    if (exp_events.size() == 0) check({tag, "_unexpected"}, 32'(obs), 32'hFFFF_FFFF);
    else check(tag, 32'(obs), 32'(exp_events.pop_front()));
  endtask

  // Event monitor: writeback pulses and completed data accesses
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (regWrite) sb_pop("wb_event", {2'b01, 1'b0, rd});
        if (bus.dmem_req && bus.dmem_ready) sb_pop("mem_event", {2'b10, 5'd0, bus.dmem_we});
      end
    end
  end

  // Entered and left at a falling edge; asserts reset asynchronously, then releases
  task automatic do_reset();
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    #3 reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_flags", 32'({halt, illegal}), 32'd0);
    check("rst_strobes", 32'({irWrite, pcWrite, regWrite, bus.dmem_req, bus.dmem_we}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_imem_req", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic run(input logic [31:0] w, input int kind, input int waits,
                     input logic [2:0] alu, input logic imm,
                     input logic [4:0] xrs1, input logic [4:0] xrs2, input logic [4:0] xrd);
    int lat;
    int cyc = 0;
    int nreg = 0;
    int nmem = 0;
    int left = waits;
    logic [2:0] end_st = 3'd0;
    logic [2:0] st;
    exp_states.delete();
    exp_states.push_back(3'd0);
    exp_states.push_back(3'd1);
    case (kind)
      K_ALU: begin
        exp_states.push_back(3'd2);
        exp_states.push_back(3'd4);
        if (xrd != 5'd0) exp_events.push_back({2'b01, 1'b0, xrd});
      end
      K_LOAD: begin
        exp_states.push_back(3'd2);
        repeat (waits + 1) exp_states.push_back(3'd3);
        exp_states.push_back(3'd4);
        exp_events.push_back(8'h80);
        if (xrd != 5'd0) exp_events.push_back({2'b01, 1'b0, xrd});
      end
      K_STORE: begin
        exp_states.push_back(3'd2);
        repeat (waits + 1) exp_states.push_back(3'd3);
        exp_events.push_back(8'h81);
      end
      K_ECALL: end_st = 3'd5;
      default: end_st = 3'd6;
    endcase
    lat = exp_states.size();
    while (1) begin
      if (cyc > 0 && (state == 3'd0 || state == 3'd5 || state == 3'd6)) break;
      if (cyc >= 40) begin
        check("timeout", 32'(cyc), 32'(lat));
        break;
      end
      // stale/garbage instr and ready pulses outside their states must be ignored
      bus.instr      = (cyc == 0) ? w : $urandom();
      bus.imem_ready = 1'b1;
      if (state == 3'd3 && left > 0) begin
        bus.dmem_ready = 1'b0;
        left--;
      end else begin
        bus.dmem_ready = 1'b1;
      end
      #1;
      st = (exp_states.size() != 0) ? exp_states.pop_front() : 3'd7;
      check("state_seq", 32'(state), 32'(st));
      if (state == 3'd0) begin
        check("fetch_strobes", 32'({bus.imem_req, irWrite, pcWrite}), 32'h7);
        check("fetch_alu_idle", 32'({aluSrcImm, ALUControl}), 32'd0);
      end else begin
        check("no_fetch_strobes", 32'({bus.imem_req, irWrite, pcWrite}), 32'd0);
      end
      if (state == 3'd2) begin
        check("exec_alu", 32'(ALUControl), 32'(alu));
        check("exec_imm", 32'(aluSrcImm), 32'(imm));
        check("exec_regs", 32'({rs1, rs2, rd}), 32'({xrs1, xrs2, xrd}));
      end
      if (state == 3'd3)
        check("mem_ctl", 32'({bus.dmem_we, aluSrcImm, ALUControl}),
              32'({(kind == K_STORE), 1'b1, 3'd0}));
      nreg += int'(regWrite);
      nmem += int'(bus.dmem_req);
      cyc++;
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    check("end_state", 32'(state), 32'(end_st));
    check("regwrite_cycles", 32'(nreg),
          32'(((kind == K_ALU || kind == K_LOAD) && xrd != 5'd0) ? 1 : 0));
    check("dmem_cycles", 32'(nmem),
          32'((kind == K_LOAD || kind == K_STORE) ? waits + 1 : 0));
  endtask

  // Absorbing state: flags held, pulsing readies must not raise any strobe
  task automatic hold(input int n, input logic [2:0] st, input logic h, input logic il);
    for (int i = 0; i < n; i++) begin
      bus.imem_ready = i[0];
      bus.dmem_ready = ~i[0];
      bus.instr      = $urandom();
      #1;
      check("hold_state", 32'(state), 32'(st));
      check("hold_flags", 32'({halt, illegal}), 32'({h, il}));
      check("hold_strobes", 32'({bus.imem_req, irWrite, pcWrite, regWrite, bus.dmem_req, bus.dmem_we}), 32'd0);
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.instr = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    op_words[0] = 32'h0020F233; op_alus[0] = 3'd2;  // and x4,x1,x2
    op_words[1] = 32'h0020E233; op_alus[1] = 3'd3;  // or
    op_words[2] = 32'h0020C233; op_alus[2] = 3'd4;  // xor
    op_words[3] = 32'h0020A233; op_alus[3] = 3'd5;  // slt
    @(negedge clk);
    do_reset();

    run(32'h00500093, K_ALU,   0, 3'd0, 1'b1, 5'd0, 5'd5, 5'd1);   // addi x1,x0,5
    run(32'h002081B3, K_ALU,   0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3);   // add
    run(32'h402081B3, K_ALU,   0, 3'd1, 1'b0, 5'd1, 5'd2, 5'd3);   // sub
    run(32'h00812283, K_LOAD,  3, 3'd0, 1'b1, 5'd2, 5'd8, 5'd5);   // lw, 3 waits
    run(32'h00512623, K_STORE, 0, 3'd0, 1'b1, 5'd2, 5'd5, 5'd12);  // sw
    run(32'h123453B7, K_ALU,   0, 3'd6, 1'b1, 5'd8, 5'd3, 5'd7);   // lui
    run(32'h00100013, K_ALU,   0, 3'd0, 1'b1, 5'd0, 5'd1, 5'd0);   // addi x0: no write
    for (int i = 0; i < 4; i++)
      run(op_words[i], K_ALU, 0, op_alus[i], 1'b0, 5'd1, 5'd2, 5'd4);
    run(32'h00812283, K_LOAD,  0, 3'd0, 1'b1, 5'd2, 5'd8, 5'd5);   // lw, zero wait
    run(32'h00512623, K_STORE, 2, 3'd0, 1'b1, 5'd2, 5'd5, 5'd12);  // sw, 2 waits

    run(32'h00000073, K_ECALL, 0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    hold(10, 3'd5, 1'b1, 1'b0);
    do_reset();

    run(32'hFFFFFFFF, K_TRAP, 0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    hold(6, 3'd6, 1'b0, 1'b1);
    do_reset();

    run(32'h4020F233, K_TRAP, 0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);    // bad f7 for AND
    hold(2, 3'd6, 1'b0, 1'b1);
    do_reset();

    // Reset in the middle of a stalled load
    bus.instr      = 32'h00812283;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 10 && state != 3'd3; i++) begin
      @(negedge clk);
      bus.imem_ready = 1'b0;
    end
    #1;
    check("midmem_reached", 32'({state, bus.dmem_req}), 32'({3'd3, 1'b1}));
    #1 reset = 1'b1;
    #1;
    check("midmem_rst_async", 32'({state, bus.dmem_req, bus.dmem_we}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("midmem_post_rst", 32'({state, bus.imem_req}), 32'({3'd0, 1'b1}));
    run(32'h00500093, K_ALU, 0, 3'd0, 1'b1, 5'd0, 5'd5, 5'd1);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(exp_events.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter XLEN, 32, instruction word width in bits; SHALL be at least 32.
REQ-002 Parameter REG_ADDR_W, 5, register index width.
REQ-003 Parameter ALU_CTRL_W, 3, ALUControl width; SHALL be at least 3.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr  in  XLEN  instruction word from instruction memory.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- dmem_ready  in  1  data access complete this cycle.
- rs1, rs2, rd  out  REG_ADDR_W each  IR[19:15], IR[24:20], IR[11:7].
- irWrite  out  1  IR load strobe.
- pcWrite  out  1  PC advance strobe.
- regWrite  out  1  register-file write strobe.
- aluSrcImm  out  1  ALU operand B is the immediate.
- ALUControl  out  ALU_CTRL_W  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, PASSB=6.
- halt  out  1  sticky; ECALL retired.
- illegal  out  1  sticky; unsupported encoding trapped.
- state  out  3  current FSM state code.

Function
REQ-005 An internal XLEN-bit instruction register (IR) SHALL hold the instruction; all decoding SHALL use IR, never instr directly.
REQ-006 States and codes SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
REQ-007 FETCH: imem_req=1; when imem_ready=1, irWrite=1, pcWrite=1, IR<=instr, next DECODE; otherwise remain in FETCH with the strobes low.
REQ-008 DECODE: LOAD (0000011, f3=010), STORE (0100011, f3=010), OP_IMM ADDI (0010011, f3=000), OP (0110011), and LUI (0110111) SHALL go to EXEC.
REQ-009 DECODE: SYSTEM (1110011) with IR[31:7]==0 (ECALL) SHALL go to HALT.
REQ-010 DECODE: any other encoding SHALL go to TRAP.
REQ-011 OP encodings SHALL be decoded only as follows; any other f3/f7 pair SHALL trap:
- f3=000, f7=0000000: ADD.
- f3=000, f7=0100000: SUB.
- f3=111, f7=0: AND.
- f3=110, f7=0: OR.
- f3=100, f7=0: XOR.
- f3=010, f7=0: SLT.
REQ-012 EXEC: ALUControl SHALL be the decoded op for OP, ADD for LOAD/STORE/ADDI and PASSB for LUI; aluSrcImm=1 for all except OP.
REQ-013 EXEC: next state SHALL be MEM for LOAD/STORE and WB otherwise.
REQ-014 MEM: dmem_req=1, with dmem_we=1 only for STORE; ALUControl=ADD and aluSrcImm=1 SHALL be held; wait until dmem_ready=1, then STORE goes to FETCH and LOAD goes to WB.
REQ-015 WB: regWrite=1 for exactly one cycle, next FETCH; regWrite SHALL never assert when rd==0 (the FSM still passes through WB).
REQ-016 HALT asserts halt=1; TRAP asserts illegal=1; both states SHALL be absorbing until reset, with every request/strobe output low.
REQ-017 Outside the states named above, imem_req, dmem_req, dmem_we, irWrite, pcWrite and regWrite SHALL be 0; ALUControl=ADD and aluSrcImm=0 when unused.
REQ-018 Latency with zero-wait memory, counted from the FETCH handshake cycle:
- ALU ops and LUI: 4 cycles.
- LOAD: 5 cycles.
- STORE: 4 cycles.
- ECALL: 2 cycles to HALT.
- Each memory wait cycle adds exactly 1 cycle.
REQ-019 imem_ready while not in FETCH and dmem_ready while not in MEM SHALL be ignored.
REQ-020 All outputs other than rs1/rs2/rd SHALL be functions of state and IR only (Moore); no input-to-output combinational path is permitted except imem_ready->irWrite/pcWrite and dmem_ready gating the MEM exit.

Reset
REQ-021 reset=1 SHALL asynchronously force state=FETCH, IR=0, halt=0 and illegal=0, and all strobes low, including mid-fetch, mid-MEM and from HALT/TRAP.
REQ-022 On the first clk edge after reset deasserts, the block SHALL be in FETCH with imem_req=1.

Verification
REQ-023 instr=0x00500093 (addi x1,x0,5), zero-wait memory -> states 0,1,2,4; aluSrcImm=1; ALUControl=0; rd=1; regWrite high exactly one cycle.
REQ-024 0x002081B3 then 0x402081B3 -> ALUControl 0 then 1; rs1=1, rs2=2, rd=3; aluSrcImm=0.
REQ-025 0x00812283 (lw x5,8(x2)) with dmem_ready low for 3 MEM cycles -> dmem_req high for 4 cycles, dmem_we=0, then WB with regWrite=1 and rd=5; total 8 cycles.
REQ-026 0x00512623 (sw) -> dmem_req=dmem_we=1 in MEM, regWrite never high, return to FETCH after 4 cycles.
REQ-027 0x00000073 -> HALT, halt=1 held for 10 cycles; 0xFFFFFFFF -> TRAP, illegal=1; pulsing imem_ready causes no strobes; reset then returns to FETCH.
REQ-028 reset asserted mid-MEM of a load -> dmem_req low and state=0 in the same cycle, without waiting for a clk edge.
